// File: rtl/jtframe_joyser.sv
// Serial joystick decoder for 74HC165-style shift-register adaptors.
// Drives the shift clock and active-low load strobe, deserialises
// PLAYERS*BUTTONS bits per frame and publishes them atomically on joy_o
// together with a one-cycle frame_o strobe.
// Optional macro JTFRAME_JOYSER_DEBOUNCE_EN: a bit only changes on joy_o
// when two consecutive frames agree on its value.
module jtframe_joyser #(
   parameter int unsigned PLAYERS = 2,
   parameter int unsigned BUTTONS = 8,
   parameter int unsigned DIV     = 16,
   parameter bit          INVERT  = 1'b0
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         joy_data_i,
   output logic                         joy_clk_o,
   output logic                         joy_load_o,
   output logic [PLAYERS*BUTTONS-1:0]   joy_o,
   output logic                         frame_o
);

   localparam int unsigned NB    = PLAYERS * BUTTONS;
   localparam int unsigned NSLOT = NB + 3;
   localparam int unsigned DW    = $clog2(DIV);
   localparam int unsigned SW    = $clog2(NSLOT);
   localparam int unsigned IW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned JW    = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;
   localparam logic [NB-1:0] INV_MASK = {NB{INVERT}};

   logic [DW-1:0] div_cnt;
   logic [SW-1:0] slot;
   logic [JW-1:0] j_cnt;
   logic [IW-1:0] grp_base;
   logic [NB-1:0] shadow;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
   logic [NB-1:0] prev;
   logic [NB-1:0] stable;
`endif

   logic          tick;
   logic          sample;
   logic          commit;
   logic [IW-1:0] idx;
   logic [NB-1:0] shadow_nx;

   // Slot decode and the shadow value including the bit captured this edge
   always_comb begin
      tick      = (div_cnt == DW'(DIV - 1));
      sample    = tick && (slot >= SW'(2)) && (slot <= SW'(NSLOT - 2));
      commit    = tick && (slot == SW'(NSLOT - 2));
      idx       = grp_base + IW'(BUTTONS - 1) - IW'(j_cnt);
      shadow_nx = shadow;
      if (sample) begin
         shadow_nx[idx] = joy_data_i;
      end
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
      stable    = ~(shadow_nx ^ prev);
`endif
   end

   // Counters, capture, commit and registered pin decode
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt    <= '0;
         slot       <= '0;
         j_cnt      <= '0;
         grp_base   <= '0;
         shadow     <= '1;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
         prev       <= '1;
`endif
         joy_o      <= ~INV_MASK;
         frame_o    <= 1'b0;
         joy_load_o <= 1'b1;
         joy_clk_o  <= 1'b0;
      end else begin
         // pins follow the counter state they were decoded from, so load
         // stays low for exactly the DIV cycles of slot 0
         joy_load_o <= (slot != SW'(0));
         joy_clk_o  <= (div_cnt >= DW'(DIV / 2));
         frame_o    <= commit;

         if (tick) begin
            div_cnt <= '0;
            slot    <= (slot == SW'(NSLOT - 1)) ? SW'(0) : slot + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (slot == SW'(0)) begin
            j_cnt    <= '0;
            grp_base <= '0;
         end else if (sample) begin
            if (j_cnt == JW'(BUTTONS - 1)) begin
               j_cnt    <= '0;
               grp_base <= grp_base + IW'(BUTTONS);
            end else begin
               j_cnt    <= j_cnt + 1'b1;
            end
         end

         shadow <= shadow_nx;

         if (commit) begin
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
            joy_o <= (joy_o & ~stable) | ((shadow_nx ^ INV_MASK) & stable);
            prev  <= shadow_nx;
`else
            joy_o <= shadow_nx ^ INV_MASK;
`endif
         end
      end
   end

endmodule

// File: tb/tb_jtframe_joyser.sv
// Bench for jtframe_joyser: two instances (2x8 DIV=4 raw, 3x12 DIV=2
// inverted) checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_jtframe_joyser;

   localparam int NP  [2] = '{2, 3};
   localparam int NBT [2] = '{8, 12};
   localparam int ND  [2] = '{4, 2};
   localparam int NI  [2] = '{0, 1};

   logic        clk = 1'b0;
   logic        rst0, rst1, dat0, dat1;
   logic        jc0, jl0, fr0, jc1, jl1, fr1;
   logic [15:0] joy0;
   logic [35:0] joy1;

   always #5 clk = ~clk;

   jtframe_joyser #(.PLAYERS(2), .BUTTONS(8), .DIV(4), .INVERT(1'b0)) u_dut0 (
      .clk_i(clk), .rst_i(rst0), .joy_data_i(dat0),
      .joy_clk_o(jc0), .joy_load_o(jl0), .joy_o(joy0), .frame_o(fr0));

   jtframe_joyser #(.PLAYERS(3), .BUTTONS(12), .DIV(2), .INVERT(1'b1)) u_dut1 (
      .clk_i(clk), .rst_i(rst1), .joy_data_i(dat1),
      .joy_clk_o(jc1), .joy_load_o(jl1), .joy_o(joy1), .frame_o(fr1));

   int          errors = 0;
   int          checks = 0;

   // reference model state
   int          cnt     [2];
   logic [47:0] cap     [2];
   logic [47:0] prevraw [2];
   logic [47:0] ejoy    [2];
   logic        efr     [2];
   logic        eload   [2];
   logic        eclk    [2];
   logic [47:0] pat     [2];
   logic        rq      [2];
   int          since   [2];
   int          first_fr[2];

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [47:0] nbmask(input int d);
      logic [47:0] m = '0;
      for (int i = 0; i < NP[d] * NBT[d]; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Serial position k of player p button-group lands at bit p*B + (B-1-j)
   function automatic logic [47:0] build(input int d, input logic [47:0] s);
      logic [47:0] v = '0;
      for (int p = 0; p < NP[d]; p++)
         for (int j = 0; j < NBT[d]; j++)
            v[p*NBT[d] + NBT[d]-1-j] = s[p*NBT[d] + j];
      return v;
   endfunction

   function automatic logic pick(input int d);
      int nb = NP[d] * NBT[d];
      int sl = cnt[d] / ND[d];
      if (sl >= 2 && sl <= nb + 1) return pat[d][sl-2];
      return 1'($urandom);
   endfunction

   task automatic model_step(input int d, input logic r, input logic dat);
      int nb, nslot, c, sl, ph;
      logic [47:0] raw, invm;
      nb    = NP[d] * NBT[d];
      nslot = nb + 3;
      invm  = (NI[d] != 0) ? nbmask(d) : 48'd0;
      if (r) begin
         cnt[d] = 0; cap[d] = '1; prevraw[d] = nbmask(d);
         ejoy[d] = nbmask(d) ^ invm;
         efr[d] = 1'b0; eload[d] = 1'b1; eclk[d] = 1'b0;
      end else begin
         c  = cnt[d];
         sl = c / ND[d];
         ph = c % ND[d];
         eload[d] = (sl != 0);
         eclk[d]  = (ph >= ND[d] / 2);
         efr[d]   = 1'b0;
         if (ph == ND[d] - 1 && sl >= 2 && sl <= nslot - 2) begin
            cap[d][sl-2] = dat;
            if (sl == nslot - 2) begin
               efr[d] = 1'b1;
               raw = build(d, cap[d]);
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
               for (int i = 0; i < nb; i++)
                  if (raw[i] == prevraw[d][i]) ejoy[d][i] = raw[i] ^ invm[i];
               prevraw[d] = raw;
`else
               ejoy[d] = raw ^ invm;
`endif
            end
         end
         cnt[d] = (c + 1) % (nslot * ND[d]);
      end
   endtask

   task automatic step();
      @(negedge clk);
      rst0 = rq[0];
      rst1 = rq[1];
      dat0 = pick(0);
      dat1 = pick(1);
      @(posedge clk);
      #1;
      model_step(0, rst0, dat0);
      model_step(1, rst1, dat1);
      since[0] = rst0 ? 0 : since[0] + 1;
      since[1] = rst1 ? 0 : since[1] + 1;
      if (fr0 && first_fr[0] < 0) first_fr[0] = since[0];
      if (fr1 && first_fr[1] < 0) first_fr[1] = since[1];
      check("load0",  48'(jl0),  48'(eload[0]));
      check("sclk0",  48'(jc0),  48'(eclk[0]));
      check("frame0", 48'(fr0),  48'(efr[0]));
      check("joy0",   48'(joy0), ejoy[0]);
      check("load1",  48'(jl1),  48'(eload[1]));
      check("sclk1",  48'(jc1),  48'(eclk[1]));
      check("frame1", 48'(fr1),  48'(efr[1]));
      check("joy1",   48'(joy1), ejoy[1]);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_frame0();
      int k = 0;
      do begin
         step();
         k++;
      end while (!efr[0] && k < 300);
      if (!efr[0]) check("frame0_timeout", 48'd0, 48'd1);
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; dat0 = 1'b1; dat1 = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cnt[d] = 0; cap[d] = '1; prevraw[d] = '1; ejoy[d] = '0;
         efr[d] = 0; eload[d] = 1; eclk[d] = 0; since[d] = 0; first_fr[d] = -1;
         rq[d] = 1'b1;
      end
      pat[0] = '1;
      pat[1] = '0;

      // reset and first frames
      run(5);
      check("rst_joy0", 48'(joy0), 48'hFFFF);
      check("rst_joy1", 48'(joy1), 48'h0);
      check("rst_load0", 48'(jl0), 48'd1);
      rq[0] = 1'b0; rq[1] = 1'b0;
      run(3 * 78);
      check("first_frame0", 48'(first_fr[0]), 48'd72);
      check("first_frame1", 48'(first_fr[1]), 48'd76);
      check("zero_stream1", 48'(joy1), 48'hF_FFFF_FFFF);

      // bit mapping: P1 start and up pressed
      pat[0] = 48'h0000_0000_FF7E;
      wait_frame0(); wait_frame0(); wait_frame0();
      check("map_ff7e", 48'(joy0), 48'hFF7E);

      // random streams changed at arbitrary points, occasional resets
      for (int it = 0; it < 60; it++) begin
         pat[0] = {$urandom, $urandom};
         pat[1] = {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) begin
            rq[$urandom_range(0, 1)] = 1'b1;
            step();
            rq[0] = 1'b0; rq[1] = 1'b0;
         end
         run($urandom_range(1, 160));
      end

      // reset in the middle of a frame
      pat[0] = '1;
      wait_frame0();
      begin
         int k = 0;
         while ((cnt[0] / 4) != 9 && k < 300) begin step(); k++; end
         if ((cnt[0] / 4) != 9) check("slot9_timeout", 48'd0, 48'd1);
      end
      rq[0] = 1'b1;
      step();
      rq[0] = 1'b0;
      check("midrst_joy0", 48'(joy0), 48'hFFFF);
      check("midrst_frame0", 48'(fr0), 48'd0);
      step();
      check("midrst_load0", 48'(jl0), 48'd0);

      // P2 up glitch for one frame, then held for two frames
      pat[0] = 48'h7FFF;
      wait_frame0();
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
      check("glitch_p2up", 48'(joy0[8]), 48'd1);
`else
      check("glitch_p2up", 48'(joy0[8]), 48'd0);
`endif
      pat[0] = 48'hFFFF;
      wait_frame0();
      check("release_p2up", 48'(joy0[8]), 48'd1);
      pat[0] = 48'h7FFF;
      wait_frame0();
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
      check("hold1_p2up", 48'(joy0[8]), 48'd1);
`else
      check("hold1_p2up", 48'(joy0[8]), 48'd0);
`endif
      wait_frame0();
      check("hold2_p2up", 48'(joy0[8]), 48'd0);
      run(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
